// File: rtl/featuremap_conv_sched_ctrl.sv
// Frame sequencer for one feature-map conv pass: gates the shared FIFO read,
// walks the padded frame and qualifies datapath results, dropping wrap columns.
module featuremap_conv_sched_ctrl #(
  parameter int WIDTH     = 112,
  parameter int HEIGHT    = 112,
  parameter int CHANNELS  = 8,
  parameter int DRAIN_MAX = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CHANNELS-1:0]           fifo_empty,
  input  logic                          out_ready,
  input  logic                          pix_valid,
  output logic                          rdreq,
  output logic                          out_keep,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          err,
  output logic [$clog2(HEIGHT+2)-1:0]   row_cnt,
  output logic [$clog2(WIDTH+2)-1:0]    col_cnt
);

  localparam int PW    = WIDTH + 2;
  localparam int PH    = HEIGHT + 2;
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int RW    = $clog2(PH);
  localparam int CW    = $clog2(PW);
  localparam int KW    = $clog2(TOTAL + 1);
  localparam int TW    = $clog2(DRAIN_MAX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] ocol;
  logic [KW-1:0] kept;
  logic [TW-1:0] tmo;
  logic          active;
  logic          last_read;
  logic          kept_full;
  logic          kept_hit;

  always_comb begin
    active     = (state == S_RUN) || (state == S_DRAIN);
    rdreq      = (state == S_RUN) && !(|fifo_empty) && out_ready;
    out_keep   = pix_valid && active && (ocol < CW'(WIDTH));
    busy       = active;
    frame_done = (state == S_DONE);
    last_read  = rdreq && (row_cnt == RW'(PH - 1)) && (col_cnt == CW'(PW - 1));
    kept_full  = (kept == KW'(TOTAL));
    // Count the final kept pixel in the same cycle it arrives.
    kept_hit   = kept_full || (out_keep && (kept == KW'(TOTAL - 1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      row_cnt <= '0;
      col_cnt <= '0;
      ocol    <= '0;
      kept    <= '0;
      tmo     <= '0;
      err     <= 1'b0;
    end else begin
      // The last read leaves the counters parked at the frame corner.
      if (rdreq && !last_read) begin
        if (col_cnt == CW'(PW - 1)) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
      if (pix_valid && active)
        ocol <= (ocol == CW'(PW - 1)) ? '0 : ocol + 1'b1;
      if (out_keep) begin
        if (kept_full) err <= 1'b1;
        else           kept <= kept + 1'b1;
      end
      if ((state == S_DRAIN) && !pix_valid) tmo <= tmo + 1'b1;
      else                                  tmo <= '0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_RUN;
            row_cnt <= '0;
            col_cnt <= '0;
            ocol    <= '0;
            kept    <= '0;
            tmo     <= '0;
            err     <= 1'b0;
          end else if (pix_valid) begin
            err <= 1'b1;
          end
        end
        S_RUN: if (last_read) state <= S_DRAIN;
        S_DRAIN: begin
          if (kept_hit) begin
            state <= S_DONE;
          end else if (!pix_valid && (tmo == TW'(DRAIN_MAX - 1))) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (pix_valid) err <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
